// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, coordinate type and path-validator FSM states.
package chess_pkg;
    typedef logic [2:0] coord_t;
    typedef logic [3:0] piece_t;
    localparam piece_t EMPTY = 4'd0;
    localparam int COLOUR_BIT = 3;
    typedef enum logic [2:0] {IDLE, SRC, SCAN, DST, DONE} state_t;
    function automatic coord_t abs_diff(coord_t a, coord_t b);
        return a >= b ? a - b : b - a;
    endfunction
endpackage

// File: rtl/validator_path_if.sv
// validator_path_if: request, board-memory read and verdict signals of the path validator.
interface validator_path_if;
    import chess_pkg::*;
    logic start_validation;
    coord_t piece_x, piece_y, move_x, move_y;
    logic geometry_ok;
    piece_t piece_read;
    coord_t validate_x, validate_y;
    logic busy, path_complete, path_valid;
    modport master (
        output start_validation, piece_x, piece_y, move_x, move_y, geometry_ok, piece_read,
        input validate_x, validate_y, busy, path_complete, path_valid
    );
    modport slave (
        input start_validation, piece_x, piece_y, move_x, move_y, geometry_ok, piece_read,
        output validate_x, validate_y, busy, path_complete, path_valid
    );
endinterface

// File: rtl/validator_path_step.sv
// validator_path_step: per-axis step sign, next square along the path, last-intermediate flag.
module validator_path_step import chess_pkg::*; (
    input  coord_t src_x,
    input  coord_t src_y,
    input  coord_t dst_x,
    input  coord_t dst_y,
    input  coord_t cur_x,
    input  coord_t cur_y,
    output coord_t next_x,
    output coord_t next_y,
    output logic   at_last
);
    logic signed [1:0] step_x, step_y;
    always_comb begin
        step_x = dst_x > src_x ? 2'sd1 : dst_x < src_x ? -2'sd1 : 2'sd0;
        step_y = dst_y > src_y ? 2'sd1 : dst_y < src_y ? -2'sd1 : 2'sd0;
        next_x = step_x == 2'sd1 ? cur_x + 3'd1 : step_x == -2'sd1 ? cur_x - 3'd1 : cur_x;
        next_y = step_y == 2'sd1 ? cur_y + 3'd1 : step_y == -2'sd1 ? cur_y - 3'd1 : cur_y;
        at_last = next_x == dst_x && next_y == dst_y;
    end
endmodule

// File: rtl/validator_path.sv
// validator_path: walks source, intermediate and destination squares through board memory.
// Define PATH_CAPTURE_EN to accept an opposite-colour piece on the destination.
module validator_path import chess_pkg::*; #(
    parameter int MEM_LATENCY = 1
) (
    input logic clk,
    input logic reset,
    validator_path_if.slave bus
);
    localparam logic [1:0] LAST = 2'(MEM_LATENCY);
    state_t state;
    coord_t src_x, src_y, dst_x, dst_y, next_x, next_y, adx, ady;
    logic [1:0] cnt;
    logic at_last, sample, occupied, reject, blocked;
`ifdef PATH_CAPTURE_EN
    logic colour;
`endif
    assign adx = abs_diff(bus.move_x, bus.piece_x);
    assign ady = abs_diff(bus.move_y, bus.piece_y);
    assign reject = !bus.geometry_ok || (adx == 3'd0 && ady == 3'd0)
                  || !(adx == 3'd0 || ady == 3'd0 || adx == ady);
    assign sample = cnt == LAST;
    assign occupied = bus.piece_read != EMPTY;
    // the source must be occupied, intermediates must be empty
    assign blocked = state == SRC ? !occupied : occupied;

    validator_path_step u_step (
        .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
        .cur_x(bus.validate_x), .cur_y(bus.validate_y),
        .next_x(next_x), .next_y(next_y), .at_last(at_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 2'd0;
            bus.validate_x <= 3'd0;
            bus.validate_y <= 3'd0;
            bus.busy <= 1'b0;
            bus.path_complete <= 1'b0;
            bus.path_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_validation) begin
                    src_x <= bus.piece_x;
                    src_y <= bus.piece_y;
                    dst_x <= bus.move_x;
                    dst_y <= bus.move_y;
                    cnt <= 2'd0;
                    bus.busy <= 1'b1;
                    bus.path_valid <= 1'b0;
                    bus.path_complete <= reject;
                    state <= reject ? DONE : SRC;
                    if (!reject) begin
                        bus.validate_x <= bus.piece_x;
                        bus.validate_y <= bus.piece_y;
                    end
                end
                SRC, SCAN: begin
                    cnt <= sample ? 2'd0 : cnt + 2'd1;
                    if (sample) begin
                        state <= blocked ? DONE : at_last ? DST : SCAN;
                        bus.path_complete <= blocked;
                        bus.validate_x <= next_x;
                        bus.validate_y <= next_y;
`ifdef PATH_CAPTURE_EN
                        if (state == SRC) colour <= bus.piece_read[COLOUR_BIT];
`endif
                    end
                end
                DST: begin
                    cnt <= sample ? 2'd0 : cnt + 2'd1;
                    if (sample) begin
                        state <= DONE;
                        bus.path_complete <= 1'b1;
`ifdef PATH_CAPTURE_EN
                        bus.path_valid <= !occupied || bus.piece_read[COLOUR_BIT] != colour;
`else
                        bus.path_valid <= !occupied;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    bus.path_complete <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
